pipe_hazard_ctrl: RTL

//  Parametrised hazard controller for the 5-stage RV32 pipeline; supersedes the

---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: M/W forwarding, load-use stall,
// taken-branch flush and a multi-cycle-op hold FSM. Define HAZ_PERF_EN for stall/flush perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4
`ifdef HAZ_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              load_e,
  input  logic              pcsrc_e,
  input  logic              mc_start_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              regwrite_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_w,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              mc_busy
`ifdef HAZ_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MC_LAT > 1) ? MC_LAT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mc_go;
  logic          mc_stall;
  logic          lw;

  assign mc_go   = mc_start_e && (MC_LAT > 1);
  assign mc_busy = (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (mc_go) begin
          state <= BUSY;
          cnt   <= CNT_INIT;
        end
        BUSY: if (cnt > CW'(1)) begin
          cnt <= cnt - 1'b1;
        end else begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The start cycle stalls from IDLE; the final BUSY cycle (cnt==1) releases the pipe.
  always_comb begin
    mc_stall = (state == IDLE) ? mc_go : (cnt > CW'(1));
  end

  always_comb begin
    forward_ae = 2'b00;
    forward_be = 2'b00;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    lw         = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    if (rst) begin
      if (regwrite_m && (rd_m == rs1_e) && (rs1_e != '0))      forward_ae = 2'b10;
      else if (regwrite_w && (rd_w == rs1_e) && (rs1_e != '0)) forward_ae = 2'b01;
      if (regwrite_m && (rd_m == rs2_e) && (rs2_e != '0))      forward_be = 2'b10;
      else if (regwrite_w && (rd_w == rs2_e) && (rs2_e != '0)) forward_be = 2'b01;
      if (mc_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
      end else if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_e && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
